// File: rtl/dm_ctl.sv
// dm_ctl: data-memory controller, one load or store per req/done handshake
// against an internal DEPTH x DW array; load results held in o_rd_data.
// Optional build macro DM_CTL_RESET_CLEAR_EN: reset walks the array writing zeros.
// Ports:
//   i_clk      system clock, rising edge
//   i_reset    synchronous active-high reset
//   i_req      access request, sampled only while idle
//   i_we       1 = store, 0 = load (sampled with i_req)
//   i_dm_adr   word address from the lookup table
//   i_wr_data  store data (sampled with i_req)
//   o_rd_data  result of the most recent load, held between loads
//   o_done     one-cycle pulse when an access completes
//   o_busy     high whenever a new request would not be accepted
module dm_ctl #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_req,
    input  logic          i_we,
    input  logic [AW-1:0] i_dm_adr,
    input  logic [DW-1:0] i_wr_data,
    output logic [DW-1:0] o_rd_data,
    output logic          o_done,
    output logic          o_busy
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DM_CTL_RESET_CLEAR_EN
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
`endif
    state_t        r_state;
    logic          r_we;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_wr_data;
    logic [DW-1:0] r_rd_data;
    logic          r_done;
    logic          r_busy;
    logic [DW-1:0] r_mem [DEPTH];
    logic          w_in_range;
    logic [IW-1:0] w_idx;
    logic          w_mem_we;
    logic [IW-1:0] w_mem_idx;
    logic [DW-1:0] w_mem_wdata;
    assign w_in_range = 32'(r_adr) < DEPTH;
    assign w_idx      = r_adr[IW-1:0];
`ifdef DM_CTL_RESET_CLEAR_EN
    logic [IW-1:0] r_cnt;
    // Single write port shared by the clear walk and normal stores; a reset
    // on the ACCESS edge suppresses the pending store.
    assign w_mem_we    = !i_reset && ((r_state == ACCESS && r_we && w_in_range) || r_state == CLEAR);
    assign w_mem_idx   = (r_state == CLEAR) ? r_cnt : w_idx;
    assign w_mem_wdata = (r_state == CLEAR) ? '0 : r_wr_data;
`else
    assign w_mem_we    = !i_reset && r_state == ACCESS && r_we && w_in_range;
    assign w_mem_idx   = w_idx;
    assign w_mem_wdata = r_wr_data;
`endif
    always_ff @(posedge i_clk) begin
        if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
`ifdef DM_CTL_RESET_CLEAR_EN
            r_state <= CLEAR;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
`else
            r_state <= IDLE;
            r_busy  <= 1'b0;
`endif
            r_done    <= 1'b0;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_state   <= ACCESS;
                        r_busy    <= 1'b1;
                        r_we      <= i_we;
                        r_adr     <= i_dm_adr;
                        r_wr_data <= i_wr_data;
                    end
                end
                ACCESS: begin
                    if (!r_we) r_rd_data <= w_in_range ? r_mem[w_idx] : '0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
`ifdef DM_CTL_RESET_CLEAR_EN
                CLEAR: begin
                    r_cnt <= r_cnt + IW'(1);
                    if (r_cnt == IW'(DEPTH - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_rd_data = r_rd_data;
    assign o_done    = r_done;
    assign o_busy    = r_busy;
endmodule

// File: tb/tb_dm_ctl.sv
// tb_dm_ctl: self-checking bench for dm_ctl (DEPTH=256 and DEPTH=128 instances
// driven in parallel); honours DM_CTL_RESET_CLEAR_EN when defined.
module tb_dm_ctl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic       we = 1'b0;
    logic [7:0] adr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rd0, rd1;
    logic       done0, done1, busy0, busy1;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [128];
    logic [7:0] rdm0 = '0, rdm1 = '0;
    logic [7:0] le0 = '0, le1 = '0;

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    always #5 clk = ~clk;

    dm_ctl u_dut0 (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_we(we), .i_dm_adr(adr),
        .i_wr_data(wdata), .o_rd_data(rd0), .o_done(done0), .o_busy(busy0)
    );
    dm_ctl #(.DEPTH(128)) u_dut1 (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_we(we), .i_dm_adr(adr),
        .i_wr_data(wdata), .o_rd_data(rd1), .o_done(done1), .o_busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model(input logic w, input logic [7:0] a, input logic [7:0] d);
        if (w) begin
            mem0[a] = d;
            if (a < 8'd128) mem1[a[6:0]] = d;
        end else begin
            rdm0 = mem0[a];
            rdm1 = (a < 8'd128) ? mem1[a[6:0]] : 8'h00;
        end
    endtask

    // Called at a negedge with both DUTs idle; returns at the negedge after DONE.
    task automatic txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] e0, input logic [7:0] e1);
        req = 1'b1; we = w; adr = a; wdata = d;
        @(negedge clk);
        chk("acc_busy0", busy0, 1); chk("acc_busy1", busy1, 1);
        chk("acc_done0", done0, 0); chk("acc_done1", done1, 0);
        chk("acc_rd0", rd0, le0);   chk("acc_rd1", rd1, le1);
        req = 1'b0; we = 1'($urandom_range(0, 1)); adr = 8'($urandom); wdata = 8'($urandom);
        @(negedge clk);
        chk("dn_done0", done0, 1); chk("dn_done1", done1, 1);
        chk("dn_busy0", busy0, 1); chk("dn_busy1", busy1, 1);
        chk("dn_rd0", rd0, e0);    chk("dn_rd1", rd1, e1);
        @(negedge clk);
        chk("id_done0", done0, 0); chk("id_done1", done1, 0);
        chk("id_busy0", busy0, 0); chk("id_busy1", busy1, 0);
        chk("id_rd0", rd0, e0);    chk("id_rd1", rd1, e1);
        le0 = e0; le1 = e1;
    endtask

    task automatic txn_m(input logic w, input logic [7:0] a, input logic [7:0] d);
        model(w, a, d);
        txn(w, a, d, rdm0, rdm1);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_rd0", rd0, 0);     chk("rst_rd1", rd1, 0);
        chk("rst_done0", done0, 0); chk("rst_done1", done1, 0);
`ifdef DM_CTL_RESET_CLEAR_EN
        chk("rst_busy0", busy0, 1); chk("rst_busy1", busy1, 1);
`else
        chk("rst_busy0", busy0, 0); chk("rst_busy1", busy1, 0);
`endif
        le0 = '0; le1 = '0; rdm0 = '0; rdm1 = '0;
`ifdef DM_CTL_RESET_CLEAR_EN
        begin
            int c0 = 0, c1 = 0, dn = 0;
            for (int i = 0; i < 256; i++) mem0[i] = '0;
            for (int i = 0; i < 128; i++) mem1[i] = '0;
            for (int k = 0; k < 300; k++) begin
                c0 += int'(busy0); c1 += int'(busy1);
                dn += int'(done0) + int'(done1);
                req = (k < 100); we = 1'b1; adr = k[7:0]; wdata = 8'hEE;
                @(negedge clk);
            end
            req = 1'b0;
            chk("clr_len0", c0, 256);
            chk("clr_len1", c1, 128);
            chk("clr_no_done", dn, 0);
        end
        txn_m(1'b0, 8'd0, 8'h00);
        txn_m(1'b0, 8'd5, 8'h00);
        txn_m(1'b0, 8'd255, 8'h00);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [9];
        logic [8:0] dv0, dv1;
        int cnt0, cnt1;
        tbl = '{
            '{1'b1, 8'd5,   8'h5A, 8'h00, 8'h00},
            '{1'b0, 8'd5,   8'h00, 8'h5A, 8'h5A},
            '{1'b0, 8'd4,   8'h00, 8'hC7, 8'hC7},
            '{1'b1, 8'd200, 8'h9C, 8'hC7, 8'hC7},
            '{1'b0, 8'd200, 8'h00, 8'h9C, 8'h00},
            '{1'b0, 8'd255, 8'h00, 8'h3C, 8'h00},
            '{1'b0, 8'd127, 8'h00, 8'hBC, 8'hBC},
            '{1'b0, 8'd72,  8'h00, 8'h8B, 8'h8B},
            '{1'b0, 8'd0,   8'h00, 8'hC3, 8'hC3}
        };
        do_reset();
        for (int a = 0; a < 256; a++) txn_m(1'b1, 8'(a), 8'(a) ^ 8'hC3);
        for (int i = 0; i < 9; i++) begin
            model(tbl[i].w, tbl[i].a, tbl[i].d);
            txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].e0, tbl[i].e1);
        end
        // req held high: accepts every third edge, inputs ignored outside IDLE
        req = 1'b1; we = 1'b1; adr = 8'd3; wdata = 8'h11;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            dv0[k-1] = done0; dv1[k-1] = done1;
            if (k == 1) begin adr = 8'd4; wdata = 8'h22; end
            if (k == 4) begin adr = 8'd5; wdata = 8'h33; end
            if (k == 8) req = 1'b0;
        end
        chk("b2b_done0", dv0, 9'b010010010);
        chk("b2b_done1", dv1, 9'b010010010);
        model(1'b1, 8'd3, 8'h11); model(1'b1, 8'd4, 8'h22); model(1'b1, 8'd5, 8'h33);
        txn_m(1'b0, 8'd3, 8'h00);
        txn_m(1'b0, 8'd4, 8'h00);
        txn_m(1'b0, 8'd5, 8'h00);
        // request pulsed during ACCESS is dropped
        txn_m(1'b1, 8'd4, 8'h44);
        req = 1'b1; we = 1'b1; adr = 8'd3; wdata = 8'hAA;
        @(negedge clk);
        adr = 8'd4; wdata = 8'hFF;
        cnt0 = 0; cnt1 = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cnt0 += int'(done0); cnt1 += int'(done1);
            if (k == 0) req = 1'b0;
        end
        chk("rej_cnt0", cnt0, 1);
        chk("rej_cnt1", cnt1, 1);
        model(1'b1, 8'd3, 8'hAA);
        txn_m(1'b0, 8'd4, 8'h00);
        txn_m(1'b0, 8'd3, 8'h00);
        // reset on the ACCESS edge of a store
        txn_m(1'b1, 8'd3, 8'h10);
        txn_m(1'b0, 8'd3, 8'h00);
        req = 1'b1; we = 1'b1; adr = 8'd3; wdata = 8'h77;
        @(negedge clk);
        do_reset();
        cnt0 = 0; cnt1 = 0;
        for (int k = 0; k < 3; k++) begin
            cnt0 += int'(done0); cnt1 += int'(done1);
            @(negedge clk);
        end
        chk("rst_nodone0", cnt0, 0);
        chk("rst_nodone1", cnt1, 0);
        txn_m(1'b0, 8'd3, 8'h00);
        for (int i = 0; i < 150; i++)
            txn_m(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
